v_xfer_seq16: RTL and testbench

V_XFER_SEQ16 -- requirements
Module: v_xfer_seq16

---
 rtl/v_xfer_seq16_pkg.sv | 42 ++++
 rtl/v_xfer_seq16_if.sv | 13 +
 rtl/v_xfer_seq16_alu.sv | 46 ++++
 rtl/v_xfer_seq16.sv | 118 +++++++++++
 tb/tb_v_xfer_seq16.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/v_xfer_seq16_pkg.sv
// Shared widths, opcode and state encodings for the register-transfer sequencer.
package v_xfer_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_INC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [SEL_W-1:0] src_a;
    logic [SEL_W-1:0] src_b;
    logic [SEL_W-1:0] dst;
  } cmd_t;

  function automatic logic [NUM_REGS-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic needs_src_b(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/v_xfer_seq16_if.sv
// Register-bank bus: one-hot read enables, per-register write strobes, shared data lines.
interface v_xfer_seq16_if;
  import v_xfer_pkg::*;

  logic [NUM_REGS-1:0] EA;
  logic [NUM_REGS-1:0] RW;
  logic [DATA_W-1:0]   BUS_IN;
  logic [DATA_W-1:0]   BUS_OUT;

  modport master (output EA, output RW, output BUS_OUT, input BUS_IN);
  modport slave  (input EA, input RW, input BUS_OUT, output BUS_IN);

endinterface

// File: rtl/v_xfer_seq16_alu.sv
// Combinational ALU: MOV/ADD/SUB/INC with zero and carry/borrow flags.
module v_alu16
  import v_xfer_pkg::*;
(
  input  op_e               OP,
  input  logic [DATA_W-1:0] TA,
  input  logic [DATA_W-1:0] TB,
  output logic [DATA_W-1:0] RESULT,
  output logic              Z,
  output logic              C
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    RESULT = '0;
    C      = 1'b0;
    case (OP)
      OP_MOV: begin
        RESULT = TA;
        C      = 1'b0;
      end
      OP_ADD: begin
        wide   = {1'b0, TA} + {1'b0, TB};
        RESULT = wide[DATA_W-1:0];
        C      = wide[DATA_W];
      end
      OP_SUB: begin
        RESULT = TA - TB;
        C      = (TA < TB);
      end
      OP_INC: begin
        wide   = {1'b0, TA} + {{DATA_W{1'b0}}, 1'b1};
        RESULT = wide[DATA_W-1:0];
        C      = wide[DATA_W];
      end
      default: begin
        RESULT = TA;
        C      = 1'b0;
      end
    endcase
    Z = (RESULT == '0);
  end

endmodule

// File: rtl/v_xfer_seq16.sv
// Register-transfer sequencer: fetches one or two registers over the shared bus,
// runs the ALU, and writes the result back to a destination register.
module v_xfer_seq16
  import v_xfer_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [SEL_W-1:0] OP,
  input  logic [SEL_W-1:0] SRC_A,
  input  logic [SEL_W-1:0] SRC_B,
  input  logic [SEL_W-1:0] DST,
  v_xfer_seq16_if.master   bus,
  output logic             BUSY,
  output logic             DONE,
  output logic             FLAG_Z,
  output logic             FLAG_C
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] ta_q, ta_d;
  logic [DATA_W-1:0] tb_q, tb_d;
  logic [DATA_W-1:0] tr_q, tr_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_c;

  v_alu16 u_alu (
    .OP     (cmd_q.op),
    .TA     (ta_q),
    .TB     (tb_q),
    .RESULT (alu_result),
    .Z      (alu_z),
    .C      (alu_c)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      tr_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      tr_q    <= tr_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Command fields are frozen at acceptance so bus inputs may change freely while busy.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    tr_d    = tr_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          cmd_d.op    = op_e'(OP);
          cmd_d.src_a = SRC_A;
          cmd_d.src_b = SRC_B;
          cmd_d.dst   = DST;
          state_d     = ST_FETCH_A;
        end
      end
      ST_FETCH_A: begin
        ta_d    = bus.BUS_IN;
        state_d = needs_src_b(cmd_q.op) ? ST_FETCH_B : ST_EXEC;
      end
      ST_FETCH_B: begin
        tb_d    = bus.BUS_IN;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        tr_d    = alu_result;
        z_d     = alu_z;
        c_d     = alu_c;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.EA = '0;
    bus.RW = '1;
    DONE   = 1'b0;
    BUSY   = (state_q != ST_IDLE);
    case (state_q)
      ST_FETCH_A: bus.EA = onehot_sel(cmd_q.src_a);
      ST_FETCH_B: bus.EA = onehot_sel(cmd_q.src_b);
      ST_WRITE:   bus.RW = ~onehot_sel(cmd_q.dst);
      ST_FIN:     DONE   = 1'b1;
      default: ;
    endcase
  end

  assign bus.BUS_OUT = tr_q;
  assign FLAG_Z      = z_q;
  assign FLAG_C      = c_q;

endmodule

// File: tb/tb_v_xfer_seq16.sv
// Directed bench for v_xfer_seq16 with a behavioural four-register bank on the bus.
module tb_v_xfer_seq16;
  import v_xfer_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic [1:0] OP = '0, SRC_A = '0, SRC_B = '0, DST = '0;
  logic       BUSY, DONE, FLAG_Z, FLAG_C;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] regs [4];
  logic        ld_en  = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [15:0] ld_val = '0;

  int          lat;
  logic [3:0]  ea2;

  v_xfer_seq16_if bif ();

  v_xfer_seq16 dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .START  (START),
    .OP     (OP),
    .SRC_A  (SRC_A),
    .SRC_B  (SRC_B),
    .DST    (DST),
    .bus    (bif.master),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .FLAG_Z (FLAG_Z),
    .FLAG_C (FLAG_C)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ld_en) regs[ld_idx] <= ld_val;
    else for (int i = 0; i < 4; i++) if (!bif.RW[i]) regs[i] <= bif.BUS_OUT;
  end

  always_comb begin
    bif.BUS_IN = '0;
    for (int i = 0; i < 4; i++) if (bif.EA[i]) bif.BUS_IN = bif.BUS_IN | regs[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ok;
    @(posedge CLK);
    #1;
    ok = ($countones(bif.EA) <= 1) && ($countones(~bif.RW) <= 1) &&
         !((|bif.EA) && !(&bif.RW));
    chk("bus_exclusive", {31'b0, ok}, 32'd1);
  endtask

  task automatic preload(input logic [1:0] idx, input logic [15:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    tick();
    ld_en = 1'b0;
  endtask

  // Accepts a command, scrambles the inputs, and counts cycles until DONE.
  task automatic run_op(input logic [1:0] op, a, b, d, input bit hold,
                        output int latency, output logic [3:0] ea_c2);
    START = 1'b1; OP = op; SRC_A = a; SRC_B = b; DST = d;
    tick();
    if (!hold) START = 1'b0;
    OP = ~op; SRC_A = ~a; SRC_B = ~b; DST = ~d;
    latency = 0;
    ea_c2   = 'x;
    for (int n = 1; n <= 10; n++) begin
      if (n == 2) ea_c2 = bif.EA;
      if (DONE) begin
        latency = n;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #2;
    chk("rst_ea", {28'b0, bif.EA}, 32'h0);
    chk("rst_rw", {28'b0, bif.RW}, 32'hF);
    chk("rst_bus_out", {16'b0, bif.BUS_OUT}, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    chk("rst_z", {31'b0, FLAG_Z}, 32'd0);
    chk("rst_c", {31'b0, FLAG_C}, 32'd0);

    preload(2'd0, 16'h1234);
    preload(2'd1, 16'h0001);
    preload(2'd2, 16'h0000);
    preload(2'd3, 16'hFFFF);
    CLR = 1'b1;

    // ADD R0+R1 -> R2, cycle by cycle
    START = 1'b1; OP = 2'b01; SRC_A = 2'd0; SRC_B = 2'd1; DST = 2'd2;
    tick();
    START = 1'b0;
    chk("add_fa_ea", {28'b0, bif.EA}, 32'h1);
    chk("add_fa_busy", {31'b0, BUSY}, 32'd1);
    tick();
    chk("add_fb_ea", {28'b0, bif.EA}, 32'h2);
    tick();
    chk("add_ex_ea", {28'b0, bif.EA}, 32'h0);
    chk("add_ex_rw", {28'b0, bif.RW}, 32'hF);
    tick();
    chk("add_wr_rw", {28'b0, bif.RW}, 32'hB);
    chk("add_wr_bus", {16'b0, bif.BUS_OUT}, 32'h1235);
    chk("add_wr_ea", {28'b0, bif.EA}, 32'h0);
    tick();
    chk("add_fin_done", {31'b0, DONE}, 32'd1);
    chk("add_fin_busy", {31'b0, BUSY}, 32'd1);
    chk("add_r2", {16'b0, regs[2]}, 32'h1235);
    chk("add_z", {31'b0, FLAG_Z}, 32'd0);
    chk("add_c", {31'b0, FLAG_C}, 32'd0);
    tick();
    chk("add_idle_done", {31'b0, DONE}, 32'd0);
    chk("add_idle_busy", {31'b0, BUSY}, 32'd0);

    // SUB R0-R1 -> R0 with borrow
    preload(2'd0, 16'h0005);
    preload(2'd1, 16'h0007);
    run_op(2'b10, 2'd0, 2'd1, 2'd0, 1'b0, lat, ea2);
    chk("sub_lat", lat, 32'd5);
    chk("sub_fetch_b", {28'b0, ea2}, 32'h2);
    chk("sub_r0", {16'b0, regs[0]}, 32'hFFFE);
    chk("sub_c", {31'b0, FLAG_C}, 32'd1);
    chk("sub_z", {31'b0, FLAG_Z}, 32'd0);
    tick();

    // MOV R1 -> R2 twice with START held high
    run_op(2'b00, 2'd1, 2'd0, 2'd2, 1'b1, lat, ea2);
    chk("mov1_lat", lat, 32'd4);
    chk("mov1_r2", {16'b0, regs[2]}, 32'h0007);
    chk("mov1_z", {31'b0, FLAG_Z}, 32'd0);
    chk("mov1_c", {31'b0, FLAG_C}, 32'd0);
    tick();
    chk("mov_idle_busy", {31'b0, BUSY}, 32'd0);
    run_op(2'b00, 2'd1, 2'd0, 2'd2, 1'b1, lat, ea2);
    chk("mov2_lat", lat, 32'd4);
    chk("mov2_no_fetch_b", {28'b0, ea2}, 32'h0);
    START = 1'b0;
    tick();
    chk("mov2_idle_busy", {31'b0, BUSY}, 32'd0);
    chk("mov_r1_kept", {16'b0, regs[1]}, 32'h0007);
    chk("mov_r0_kept", {16'b0, regs[0]}, 32'hFFFE);

    // INC R3 wraps to zero
    run_op(2'b11, 2'd3, 2'd0, 2'd3, 1'b0, lat, ea2);
    chk("inc_lat", lat, 32'd4);
    chk("inc_no_fetch_b", {28'b0, ea2}, 32'h0);
    chk("inc_r3", {16'b0, regs[3]}, 32'h0000);
    chk("inc_z", {31'b0, FLAG_Z}, 32'd1);
    chk("inc_c", {31'b0, FLAG_C}, 32'd1);
    tick();

    // Reset during FETCH_B of an ADD
    START = 1'b1; OP = 2'b01; SRC_A = 2'd0; SRC_B = 2'd1; DST = 2'd2;
    tick();
    START = 1'b0;
    tick();
    chk("abort_fb_ea", {28'b0, bif.EA}, 32'h2);
    #1 CLR = 1'b0;
    #1;
    chk("abort_ea", {28'b0, bif.EA}, 32'h0);
    chk("abort_rw", {28'b0, bif.RW}, 32'hF);
    chk("abort_busy", {31'b0, BUSY}, 32'd0);
    chk("abort_done", {31'b0, DONE}, 32'd0);
    chk("abort_z", {31'b0, FLAG_Z}, 32'd0);
    chk("abort_c", {31'b0, FLAG_C}, 32'd0);
    chk("abort_bus_out", {16'b0, bif.BUS_OUT}, 32'h0);
    tick();
    tick();
    CLR = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", {31'b0, DONE}, 32'd0);
    end
    chk("abort_r2_kept", {16'b0, regs[2]}, 32'h0007);

    // First START accepted on the first edge after release; DST aliases both sources
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    run_op(2'b01, 2'd2, 2'd2, 2'd2, 1'b0, lat, ea2);
    chk("post_rst_lat", lat, 32'd5);
    chk("alias_fetch_b", {28'b0, ea2}, 32'h4);
    chk("alias_r2", {16'b0, regs[2]}, 32'h000E);
    chk("alias_c", {31'b0, FLAG_C}, 32'd0);
    tick();
    chk("final_busy", {31'b0, BUSY}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
